seq_mul_param: RTL and testbench

Parametrised shift-add sequential multiplier. It generalises the team's fixed 4x4 unsigned sequential multiplier to WIDTH x WIDTH operands, with a per-operation signed/unsigned mode. It uses an explicit start/busy/done handshake and a registered, held product. It sits behind the project top-level as the arithmetic core, fed directly from input pins or registers.

---
 rtl/seq_mul_pkg.sv | 15 +
 rtl/seq_mul_addsub.sv | 29 ++
 rtl/seq_mul_param.sv | 98 +++++++++
 tb/tb_seq_mul_param.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mul_pkg.sv
// Shared definitions for the parametrised shift-add sequential multiplier.
package seq_mul_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Counter must hold WIDTH-1 and still count one past it without aliasing.
   function automatic int cnt_width(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/seq_mul_addsub.sv
// One shift-add step: WIDTH+1-bit add/subtract with signed or unsigned extension.
module seq_mul_addsub
   import seq_mul_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH:0]   acc,
   input  logic [WIDTH-1:0] mcand,
   input  logic             add_en,
   input  logic             sgn,
   input  logic             sub,
   output logic [WIDTH+1:0] sum
);

   logic [WIDTH:0]   ext;
   logic [WIDTH:0]   addend;
   logic [WIDTH+1:0] acc_x;
   logic [WIDTH+1:0] add_x;

   // The extra top bit keeps the carry (unsigned) or the true sign (signed).
   always_comb begin
      ext    = sgn ? {mcand[WIDTH-1], mcand} : {1'b0, mcand};
      addend = add_en ? ext : '0;
      acc_x  = sgn ? {acc[WIDTH], acc} : {1'b0, acc};
      add_x  = sgn ? {addend[WIDTH], addend} : {1'b0, addend};
      sum    = sub ? (acc_x - add_x) : (acc_x + add_x);
   end

endmodule

// File: rtl/seq_mul_param.sv
// WIDTH x WIDTH shift-add multiplier with signed/unsigned mode, start/busy/done handshake
// and a held product.
module seq_mul_param
   import seq_mul_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = cnt_width(WIDTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               signed_mode,
   input  logic               abort,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product,
   output state_t             state_dbg
);

   // Handshake: start is sampled only in IDLE/DONE; busy covers exactly the WIDTH
   // iteration cycles; done pulses for one cycle as product updates.
   state_t           state;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplr;
   logic [WIDTH:0]   acc;
   logic [CNT_W-1:0] cnt;
   logic             sgn;
   logic             last;
   logic [WIDTH+1:0] sum;

   assign last      = (cnt == CNT_W'(WIDTH - 1));
   assign state_dbg = state;

   // The multiplier MSB carries negative weight in two's complement.
   seq_mul_addsub #(.WIDTH(WIDTH)) u_addsub (
      .acc    (acc),
      .mcand  (mcand),
      .add_en (mplr[0]),
      .sgn    (sgn),
      .sub    (sgn & last),
      .sum    (sum)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         product <= '0;
         mcand   <= '0;
         mplr    <= '0;
         acc     <= '0;
         cnt     <= '0;
         sgn     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               done <= 1'b0;
               if (start) begin
                  mcand <= a;
                  mplr  <= b;
                  sgn   <= signed_mode;
                  acc   <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= ST_RUN;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_RUN: begin
               if (abort) begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end else begin
                  acc  <= sum[WIDTH+1:1];
                  mplr <= {sum[0], mplr[WIDTH-1:1]};
                  cnt  <= cnt + CNT_W'(1);
                  if (last) begin
                     product <= {sum[WIDTH:1], sum[0], mplr[WIDTH-1:1]};
                     done    <= 1'b1;
                     busy    <= 1'b0;
                     state   <= ST_DONE;
                  end
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_mul_param.sv
// Self-checking bench for seq_mul_param at WIDTH=4 and WIDTH=8 against an arithmetic model.
module tb_seq_mul_param;
   import seq_mul_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   logic       start4 = 1'b0, sgn4 = 1'b0, abort4 = 1'b0;
   logic [3:0] a4 = '0, b4 = '0;
   logic       busy4, done4;
   logic [7:0] prod4;
   state_t     st4;

   logic       start8 = 1'b0, sgn8 = 1'b0, abort8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       busy8, done8;
   logic [15:0] prod8;
   state_t     st8;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seq_mul_param #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .signed_mode(sgn4), .abort(abort4),
      .a(a4), .b(b4), .busy(busy4), .done(done4), .product(prod4), .state_dbg(st4)
   );

   seq_mul_param #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sgn8), .abort(abort8),
      .a(a8), .b(b8), .busy(busy8), .done(done8), .product(prod8), .state_dbg(st8)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: interpret operands by mode, multiply as integers, keep 2*w bits.
   function automatic logic [15:0] ref_mul(input int w, input logic [7:0] x, input logic [7:0] y,
                                           input logic s);
      longint sx, sy, p, mask;
      mask = (longint'(1) << w) - 1;
      sx = longint'(x) & mask;
      sy = longint'(y) & mask;
      if (s && x[w-1]) sx = sx - (longint'(1) << w);
      if (s && y[w-1]) sy = sy - (longint'(1) << w);
      p = sx * sy;
      return 16'(p & ((longint'(1) << (2 * w)) - 1));
   endfunction

   // Called at a negedge after start was driven; waits for done with a bound.
   task automatic wait_done(input int w, output int lat, output int bcyc);
      bit seen;
      lat = 0;
      bcyc = 0;
      seen = 0;
      for (int k = 1; k <= 40 && !seen; k++) begin
         @(negedge clk);
         start4 = 1'b0; start8 = 1'b0; abort4 = 1'b0; abort8 = 1'b0;
         a4 = 4'($urandom); b4 = 4'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
         if ((w == 4) ? busy4 : busy8) bcyc++;
         if ((w == 4) ? done4 : done8) begin
            seen = 1;
            lat = k;
         end
      end
      if (!seen) check("done_timeout", 16'd0, 16'd1);
   endtask

   task automatic run_op(input int w, input logic [7:0] x, input logic [7:0] y, input logic s,
                         output logic [15:0] prod, output int lat, output int bcyc);
      if (w == 4) begin
         a4 = x[3:0]; b4 = y[3:0]; sgn4 = s; start4 = 1'b1;
      end else begin
         a8 = x; b8 = y; sgn8 = s; start8 = 1'b1;
      end
      wait_done(w, lat, bcyc);
      prod = (w == 4) ? {8'h00, prod4} : prod8;
   endtask

   logic [15:0] p;
   int lat, bcyc, dcount, stride, offs, idx;
   logic [7:0] sa_tab [4] = '{8'h8, 8'h8, 8'h5, 8'h0};
   logic [7:0] sb_tab [4] = '{8'h8, 8'h7, 8'hD, 8'hF};
   logic [7:0] sp_tab [4] = '{8'h40, 8'hC8, 8'hF1, 8'h00};

   initial begin
      // Reset state
      @(negedge clk);
      check("rst_busy4", 16'(busy4), 16'd0);
      check("rst_done4", 16'(done4), 16'd0);
      check("rst_prod4", 16'(prod4), 16'd0);
      check("rst_state4", 16'(st4), 16'(ST_IDLE));
      check("rst_prod8", prod8, 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Unsigned 15*15, latency and busy length, single done pulse
      run_op(4, 8'd15, 8'd15, 1'b0, p, lat, bcyc);
      check("u15x15_prod", p, 16'h00E1);
      check("u15x15_lat", 16'(lat), 16'd5);
      check("u15x15_busy", 16'(bcyc), 16'd4);
      @(negedge clk);
      check("u15x15_no_second_done", 16'(done4), 16'd0);
      check("u15x15_held", 16'(prod4), 16'h00E1);
      check("u15x15_idle", 16'(st4), 16'(ST_IDLE));

      // Signed directed cases
      for (int i = 0; i < 4; i++) begin
         run_op(4, sa_tab[i], sb_tab[i], 1'b1, p, lat, bcyc);
         check("signed_dir_prod", p, 16'(sp_tab[i]));
         check("signed_dir_lat", 16'(lat), 16'd5);
         @(negedge clk);
      end

      // WIDTH=8 extremes
      run_op(8, 8'd255, 8'd255, 1'b0, p, lat, bcyc);
      check("w8_unsigned_prod", p, 16'hFE01);
      check("w8_unsigned_lat", 16'(lat), 16'd9);
      check("w8_unsigned_busy", 16'(bcyc), 16'd8);
      run_op(8, 8'd255, 8'd255, 1'b1, p, lat, bcyc);
      check("w8_signed_prod", p, 16'h0001);
      check("w8_signed_lat", 16'(lat), 16'd9);
      run_op(8, 8'h80, 8'h80, 1'b1, p, lat, bcyc);
      check("w8_minsq_prod", p, 16'h4000);
      @(negedge clk);

      // start during RUN is ignored
      a4 = 4'd3; b4 = 4'd4; sgn4 = 1'b0; start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      check("run_busy", 16'(busy4), 16'd1);
      @(negedge clk);
      a4 = 4'd9; b4 = 4'd9; start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      wait_done(4, lat, bcyc);
      check("ignore_start_prod", 16'(prod4), 16'h000C);
      check("ignore_start_lat", 16'(lat), 16'd2);
      // back-to-back start in the DONE cycle
      a4 = 4'd2; b4 = 4'd7; start4 = 1'b1;
      wait_done(4, lat, bcyc);
      check("b2b_prod", 16'(prod4), 16'h000E);
      check("b2b_lat", 16'(lat), 16'd5);
      check("b2b_busy", 16'(bcyc), 16'd4);
      @(negedge clk);

      // abort mid-run keeps the previous product
      run_op(4, 8'd3, 8'd4, 1'b0, p, lat, bcyc);
      @(negedge clk);
      a4 = 4'd7; b4 = 4'd7; start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      @(negedge clk);
      abort4 = 1'b1;
      @(negedge clk);
      abort4 = 1'b0;
      check("abort_busy", 16'(busy4), 16'd0);
      check("abort_state", 16'(st4), 16'(ST_IDLE));
      dcount = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (done4) dcount++;
      end
      check("abort_no_done", 16'(dcount), 16'd0);
      check("abort_prod_held", 16'(prod4), 16'h000C);

      // start wins over abort in IDLE
      a4 = 4'd2; b4 = 4'd3; sgn4 = 1'b0; start4 = 1'b1; abort4 = 1'b1;
      wait_done(4, lat, bcyc);
      check("start_over_abort_prod", 16'(prod4), 16'h0006);
      check("start_over_abort_lat", 16'(lat), 16'd5);
      @(negedge clk);

      // asynchronous reset mid-run
      a4 = 4'd5; b4 = 4'd5; start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("arst_busy", 16'(busy4), 16'd0);
      check("arst_done", 16'(done4), 16'd0);
      check("arst_prod", 16'(prod4), 16'd0);
      check("arst_state", 16'(st4), 16'(ST_IDLE));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Full operand sweep in a random permutation, both modes
      for (int m = 0; m < 2; m++) begin
         stride = 2 * $urandom_range(0, 127) + 1;
         offs = $urandom_range(0, 255);
         for (int i = 0; i < 256; i++) begin
            idx = (i * stride + offs) & 255;
            run_op(4, 8'(idx >> 4), 8'(idx & 15), m[0], p, lat, bcyc);
            check("sweep_prod", p, ref_mul(4, 8'(idx >> 4), 8'(idx & 15), m[0]));
            check("sweep_lat", 16'(lat), 16'd5);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
         end
      end

      // Random WIDTH=8 operations in both modes
      for (int i = 0; i < 40; i++) begin
         logic [7:0] x, y;
         logic s;
         x = 8'($urandom);
         y = 8'($urandom);
         s = 1'($urandom);
         run_op(8, x, y, s, p, lat, bcyc);
         check("w8_rand_prod", p, ref_mul(8, x, y, s));
         check("w8_rand_lat", 16'(lat), 16'd9);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
